avsdpll_seq_ctrl: RTL and testbench

Parametrised digital sequencer and lock monitor for the analog PLL macro. It runs on a stable system clock and drives the macro's active-low enables (ENb_VCO, ENb_CP) and its feedback-divider select bus (B) in a fixed power-up order. It measures the PLL output frequency from a divided toggle signal and declares lock after consecutive in-tolerance windows. Unlike the bare macro, it adds configurable divider width, lock/loss detection, retry on lock loss and a terminal FAIL state.

---
 rtl/avsdpll_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_avsdpll_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avsdpll_seq_ctrl.sv
// Power-up sequencer and frequency lock monitor for the analog PLL macro.
// Brings up the VCO, then the charge pump, measures the divided feedback
// toggle over fixed windows, and declares lock after consecutive good windows.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | macro off, waiting for START
//   SETTLE   | VCO running open loop (CP off) for SETTLE_CYC cycles
//   ACQUIRE  | loop closed, counting consecutive good windows
//   LOCKED   | lock declared; first bad window triggers a retry
//   FAIL     | retries exhausted, macro off, waiting for START
module avsdpll_seq_ctrl #(
    parameter int DIV_W       = 4,
    parameter int CNT_W       = 16,
    parameter int WIN_CYC     = 1024,
    parameter int SETTLE_CYC  = 256,
    parameter int TOL         = 2,
    parameter int LOCK_WIN    = 4,
    parameter int ACQ_MAX_WIN = 32,
    parameter int MAX_RETRY   = 3
) (
    input  logic             CLK,
    input  logic             RSTb,
    input  logic             START,
    input  logic             STOP,
    input  logic [DIV_W-1:0] DIV_SEL,
    input  logic [CNT_W-1:0] EXP_CNT,
    input  logic             FB_TGL,
    output logic [DIV_W-1:0] B,
    output logic             ENb_VCO,
    output logic             ENb_CP,
    output logic             LOCKED,
    output logic             FAIL,
    output logic             BUSY,
    output logic [CNT_W-1:0] MEAS_CNT,
    output logic [2:0]       STATE
);

    localparam int WIN_W  = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam int STL_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int GOOD_W = (LOCK_WIN > 0) ? $clog2(LOCK_WIN + 1) : 1;
    localparam int ACQ_W  = (ACQ_MAX_WIN > 0) ? $clog2(ACQ_MAX_WIN + 1) : 1;
    localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAIL    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   exp_q, exp_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [ACQ_W-1:0]   acq_win_q, acq_win_d;
    logic [STL_W-1:0]   settle_q, settle_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   edge_q, edge_d;
    logic [CNT_W-1:0]   meas_q, meas_d;
    logic               enb_vco_q, enb_vco_d;
    logic               enb_cp_q, enb_cp_d;
    logic               locked_q, locked_d;
    logic               fail_q, fail_d;
    logic               busy_q, busy_d;
    logic [2:0]         sync_q, sync_d;

    logic               tgl_evt;
    logic               measuring;
    logic               win_last;
    logic [CNT_W-1:0]   edge_fin;
    logic [CNT_W:0]     diff_w;
    logic [CNT_W:0]     abs_w;
    logic               win_good;
    logic [GOOD_W-1:0]  good_inc;
    logic [ACQ_W-1:0]   acq_inc;
    logic               retry_evt;

    // FB_TGL is asynchronous: two flops to resolve metastability, third for edge detect
    assign sync_d  = {sync_q[1:0], FB_TGL};
    assign tgl_evt = sync_q[1] ^ sync_q[2];

    assign measuring = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);
    assign win_last  = (win_q == WIN_W'(WIN_CYC - 1));
    // Counter saturates rather than wrapping so a grossly fast VCO still reads as bad
    assign edge_fin  = (&edge_q) ? edge_q : edge_q + CNT_W'(tgl_evt);
    // One extra bit so the difference cannot wrap before the tolerance compare
    assign diff_w    = {1'b0, edge_fin} - {1'b0, exp_q};
    assign abs_w     = diff_w[CNT_W] ? -diff_w : diff_w;
    assign win_good  = (abs_w <= (CNT_W + 1)'(TOL));
    assign good_inc  = good_q + GOOD_W'(1);
    assign acq_inc   = acq_win_q + ACQ_W'(1);

    // Next-state, window bookkeeping and registered-output decode
    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        exp_d     = exp_q;
        retry_d   = retry_q;
        good_d    = good_q;
        acq_win_d = acq_win_q;
        settle_d  = settle_q;
        win_d     = '0;
        edge_d    = '0;
        meas_d    = meas_q;
        retry_evt = 1'b0;

        if (measuring) begin
            if (win_last) begin
                meas_d = edge_fin;
            end else begin
                win_d  = win_q + WIN_W'(1);
                edge_d = edge_fin;
            end
        end

        case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (START) begin
                    b_d       = DIV_SEL;
                    exp_d     = EXP_CNT;
                    retry_d   = '0;
                    good_d    = '0;
                    acq_win_d = '0;
                    settle_d  = STL_W'(SETTLE_CYC - 1);
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_ACQUIRE;
                end else begin
                    settle_d = settle_q - STL_W'(1);
                end
            end
            ST_ACQUIRE: begin
                if (win_last) begin
                    acq_win_d = acq_inc;
                    if (win_good) begin
                        good_d = good_inc;
                    end else begin
                        good_d = '0;
                    end
                    // Reaching lock on the final allowed window wins over the timeout
                    if (win_good && (good_inc == GOOD_W'(LOCK_WIN))) begin
                        state_d = ST_LOCKED;
                    end else if (acq_inc == ACQ_W'(ACQ_MAX_WIN)) begin
                        retry_evt = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (win_last && !win_good) begin
                    retry_evt = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (retry_evt) begin
            if (retry_q == RTY_W'(MAX_RETRY)) begin
                state_d = ST_FAIL;
            end else begin
                retry_d   = retry_q + RTY_W'(1);
                good_d    = '0;
                acq_win_d = '0;
                settle_d  = STL_W'(SETTLE_CYC - 1);
                state_d   = ST_SETTLE;
            end
        end

        // STOP overrides everything; B is deliberately left alone
        if (STOP) begin
            state_d   = ST_IDLE;
            retry_d   = '0;
            good_d    = '0;
            acq_win_d = '0;
            settle_d  = '0;
            win_d     = '0;
            edge_d    = '0;
        end

        enb_vco_d = !((state_d == ST_SETTLE) || (state_d == ST_ACQUIRE) ||
                      (state_d == ST_LOCKED));
        enb_cp_d  = !((state_d == ST_ACQUIRE) || (state_d == ST_LOCKED));
        locked_d  = (state_d == ST_LOCKED);
        fail_d    = (state_d == ST_FAIL);
        busy_d    = !enb_vco_d;
    end

    // Feedback toggle synchroniser
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Sequencer state, counters and registered outputs
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q   <= ST_IDLE;
            b_q       <= '0;
            exp_q     <= '0;
            retry_q   <= '0;
            good_q    <= '0;
            acq_win_q <= '0;
            settle_q  <= '0;
            win_q     <= '0;
            edge_q    <= '0;
            meas_q    <= '0;
            enb_vco_q <= 1'b1;
            enb_cp_q  <= 1'b1;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            exp_q     <= exp_d;
            retry_q   <= retry_d;
            good_q    <= good_d;
            acq_win_q <= acq_win_d;
            settle_q  <= settle_d;
            win_q     <= win_d;
            edge_q    <= edge_d;
            meas_q    <= meas_d;
            enb_vco_q <= enb_vco_d;
            enb_cp_q  <= enb_cp_d;
            locked_q  <= locked_d;
            fail_q    <= fail_d;
            busy_q    <= busy_d;
        end
    end

    assign B        = b_q;
    assign ENb_VCO  = enb_vco_q;
    assign ENb_CP   = enb_cp_q;
    assign LOCKED   = locked_q;
    assign FAIL     = fail_q;
    assign BUSY     = busy_q;
    assign MEAS_CNT = meas_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_avsdpll_seq_ctrl.sv
// Bench for the PLL sequencer: one instance with 16-bit counters for the
// sequencing scenarios, a second with 4-bit counters for saturation.
module tb_avsdpll_seq_ctrl;

    localparam int WIN = 64;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        fb_tgl = 1'b0;
    logic [3:0]  div_sel = '0;
    logic [15:0] exp_cnt = '0;
    logic [3:0]  b;
    logic        enb_vco, enb_cp, locked, fail_o, busy;
    logic [15:0] meas_cnt;
    logic [2:0]  state;

    logic        start2 = 1'b0;
    logic        fb_tgl2 = 1'b0;
    logic [3:0]  exp2 = 4'd10;
    logic [3:0]  b2;
    logic        enb_vco2, enb_cp2, locked2, fail2, busy2;
    logic [3:0]  meas2;
    logic [2:0]  state2;

    typedef struct {
        int cnt;
        int st;
    } win_exp_t;

    win_exp_t sb_q[$];
    win_exp_t sat_q[$];
    int n_checks = 0;
    int n_errors = 0;
    bit sat_done = 1'b0;

    always #5 clk = ~clk;

    avsdpll_seq_ctrl #(
        .DIV_W(4), .CNT_W(16), .WIN_CYC(WIN), .SETTLE_CYC(16), .TOL(2),
        .LOCK_WIN(4), .ACQ_MAX_WIN(8), .MAX_RETRY(1)
    ) dut (
        .CLK(clk), .RSTb(rst_b), .START(start), .STOP(stop),
        .DIV_SEL(div_sel), .EXP_CNT(exp_cnt), .FB_TGL(fb_tgl),
        .B(b), .ENb_VCO(enb_vco), .ENb_CP(enb_cp), .LOCKED(locked),
        .FAIL(fail_o), .BUSY(busy), .MEAS_CNT(meas_cnt), .STATE(state)
    );

    avsdpll_seq_ctrl #(
        .DIV_W(4), .CNT_W(4), .WIN_CYC(WIN), .SETTLE_CYC(16), .TOL(2),
        .LOCK_WIN(4), .ACQ_MAX_WIN(8), .MAX_RETRY(1)
    ) dut_sat (
        .CLK(clk), .RSTb(rst_b), .START(start2), .STOP(1'b0),
        .DIV_SEL(4'd7), .EXP_CNT(exp2), .FB_TGL(fb_tgl2),
        .B(b2), .ENb_VCO(enb_vco2), .ENb_CP(enb_cp2), .LOCKED(locked2),
        .FAIL(fail2), .BUSY(busy2), .MEAS_CNT(meas2), .STATE(state2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Bounded wait; returns just after the negedge on which the state is seen
    task automatic wait_state(input int st, input int budget);
        int k = 0;
        while ((32'(state) != st) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        check_eq("wait_state", 32'(state), st);
    endtask

    // One measurement window aligned to the DUT window: n feedback transitions
    // placed mid-window, expected count and follow-on state queued up front.
    task automatic run_window(input int n, input int st_after, input bit busy_start);
        win_exp_t e;
        win_exp_t got;
        e.cnt = n;
        e.st  = st_after;
        sb_q.push_back(e);
        for (int c = 1; c <= WIN; c++) begin
            @(posedge clk); #1;
            if (c >= 4 && c < 4 + 2 * n && ((c - 4) % 2 == 0)) fb_tgl = ~fb_tgl;
            if (busy_start && c == 20) start = 1'b1;
            if (c == 21) start = 1'b0;
        end
        got = sb_q.pop_front();
        check_eq("meas_cnt", 32'(meas_cnt), got.cnt);
        check_eq("win_state", 32'(state), got.st);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_enb_vco", 32'(enb_vco), 1);
        check_eq("rst_enb_cp", 32'(enb_cp), 1);
        check_eq("rst_b", 32'(b), 0);
        check_eq("rst_meas", 32'(meas_cnt), 0);
        check_eq("rst_locked", 32'(locked), 0);
        check_eq("rst_fail", 32'(fail_o), 0);
        check_eq("rst_busy", 32'(busy), 0);

        rst_b = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check_eq("idle_hold", 32'(state), 0);
        check_eq("idle_enb_vco", 32'(enb_vco), 1);

        // Nominal lock; inputs changed after START must be ignored
        div_sel = 4'hA;
        exp_cnt = 16'd16;
        pulse_start();
        check_eq("start_state", 32'(state), 1);
        check_eq("start_enb_vco", 32'(enb_vco), 0);
        check_eq("start_enb_cp", 32'(enb_cp), 1);
        check_eq("start_b", 32'(b), 32'hA);
        check_eq("start_busy", 32'(busy), 1);
        div_sel = 4'h5;
        exp_cnt = 16'd3;
        repeat (15) @(posedge clk);
        #1;
        check_eq("settle_cp_off", 32'(enb_cp), 1);
        check_eq("settle_state", 32'(state), 1);
        @(posedge clk); #1;
        check_eq("acq_cp_on", 32'(enb_cp), 0);
        check_eq("acq_state", 32'(state), 2);
        run_window(16, 2, 1'b0);
        run_window(16, 2, 1'b1);
        run_window(16, 2, 1'b0);
        run_window(16, 3, 1'b0);
        check_eq("lock_flag", 32'(locked), 1);
        check_eq("lock_b_held", 32'(b), 32'hA);
        check_eq("lock_busy", 32'(busy), 1);

        // Loss of feedback while locked: first retry back to SETTLE
        run_window(16, 3, 1'b0);
        run_window(0, 1, 1'b0);
        check_eq("retry_cp_off", 32'(enb_cp), 1);
        check_eq("retry_vco_on", 32'(enb_vco), 0);
        check_eq("retry_locked", 32'(locked), 0);
        wait_state(2, 40);

        // Tolerance edges: 14 and 18 good, 13 bad resets the run of good windows
        run_window(14, 2, 1'b0);
        run_window(18, 2, 1'b0);
        run_window(13, 2, 1'b0);
        run_window(16, 2, 1'b0);
        run_window(16, 2, 1'b0);
        run_window(16, 2, 1'b0);
        run_window(16, 3, 1'b0);

        // Second loss with retries exhausted
        run_window(0, 5, 1'b0);
        check_eq("fail_flag", 32'(fail_o), 1);
        check_eq("fail_enb_vco", 32'(enb_vco), 1);
        check_eq("fail_enb_cp", 32'(enb_cp), 1);
        check_eq("fail_busy", 32'(busy), 0);
        check_eq("fail_locked", 32'(locked), 0);
        check_eq("fail_b_held", 32'(b), 32'hA);

        // Restart from FAIL; acquisition timeout, retry, timeout again
        div_sel = 4'h3;
        exp_cnt = 16'd16;
        pulse_start();
        check_eq("refail_state", 32'(state), 1);
        check_eq("refail_b", 32'(b), 32'h3);
        wait_state(2, 40);
        for (int i = 0; i < 7; i++) run_window(0, 2, 1'b0);
        run_window(0, 1, 1'b0);
        wait_state(2, 40);
        for (int i = 0; i < 7; i++) run_window(0, 2, 1'b0);
        run_window(0, 5, 1'b0);
        check_eq("timeout_fail", 32'(fail_o), 1);
        check_eq("timeout_b", 32'(b), 32'h3);
        check_eq("timeout_enb_vco", 32'(enb_vco), 1);

        // STOP and START together during ACQUIRE
        div_sel = 4'h9;
        pulse_start();
        check_eq("restart_state", 32'(state), 1);
        wait_state(2, 40);
        div_sel = 4'h6;
        @(posedge clk); #1;
        stop = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        start = 1'b0;
        check_eq("stop_state", 32'(state), 0);
        check_eq("stop_enb_vco", 32'(enb_vco), 1);
        check_eq("stop_enb_cp", 32'(enb_cp), 1);
        check_eq("stop_b_held", 32'(b), 32'h9);
        check_eq("stop_busy", 32'(busy), 0);
        repeat (50) @(posedge clk);
        #1;
        check_eq("stop_idle", 32'(state), 0);

        // Lock again, then asynchronous reset in the middle of LOCKED
        pulse_start();
        wait_state(2, 40);
        run_window(16, 2, 1'b0);
        run_window(16, 2, 1'b0);
        run_window(16, 2, 1'b0);
        run_window(16, 3, 1'b0);
        check_eq("relock_b", 32'(b), 32'h6);
        rst_b = 1'b0;
        #1;
        check_eq("arst_state", 32'(state), 0);
        check_eq("arst_enb_vco", 32'(enb_vco), 1);
        check_eq("arst_enb_cp", 32'(enb_cp), 1);
        check_eq("arst_b", 32'(b), 0);
        check_eq("arst_locked", 32'(locked), 0);
        check_eq("arst_meas", 32'(meas_cnt), 0);
        check_eq("arst_busy", 32'(busy), 0);
        #20;
        rst_b = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check_eq("post_rst_idle", 32'(state), 0);
        check_eq("post_rst_vco", 32'(enb_vco), 1);

        wait (sat_done);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // 4-bit counter instance: 40 transitions in a window must read 15, not wrap
    initial begin
        win_exp_t e;
        win_exp_t got;
        int k;
        @(posedge rst_b);
        repeat (5) @(posedge clk);
        #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        k = 0;
        while ((state2 != 3'd2) && (k < 40)) begin
            @(negedge clk);
            k++;
        end
        check_eq("sat_acq", 32'(state2), 2);
        for (int w = 0; w < 2; w++) begin
            e.cnt = 15;
            e.st  = 2;
            sat_q.push_back(e);
            for (int c = 1; c <= WIN; c++) begin
                @(posedge clk); #1;
                if (c >= 4 && c < 44) fb_tgl2 = ~fb_tgl2;
            end
            got = sat_q.pop_front();
            check_eq("sat_meas", 32'(meas2), got.cnt);
            check_eq("sat_state", 32'(state2), got.st);
        end
        check_eq("sat_not_locked", 32'(locked2), 0);
        sat_done = 1'b1;
    end

endmodule
